execute_mc: RTL and testbench
=============================

EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 Parameter DATA_W, default 16, datapath width (≥16); IR stays 16 bits.
REQ-002 Parameter N_BYP, default 2, number of bypass sources (≥1).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid / in_ready  in / out  1  upstream handshake; transfer when both high on a clk edge.
REQ-006 IR  in  16  instruction; npc_in  in  DATA_W  next PC.
REQ-007 alu_op  in  3  0 ADD, 1 AND, 2 NOT, 3 PASS2, 4 MUL, 5-7 reserved.
REQ-008 op2_sel  in  1  0 imm5, 1 register operand; pcsel1  in  2  0 off11, 1 off9, 2 off6, 3 zero; pcsel2  in  1  0 VSR1, 1 npc_in.
REQ-009 VSR1, VSR2  in  DATA_W  register-file operands.
REQ-010 byp_sel1, byp_sel2  in  N_BYP  per-source bypass request for operand 1 / 2.
REQ-011 byp_val  in  N_BYP*DATA_W  bypass values, source k at bits [k*DATA_W +: DATA_W].
REQ-012 out_valid / out_ready  out / in  1  downstream handshake.
REQ-013 aluout, pcout, M_Data  out  DATA_W; dr, NZP  out  3; IR_Exec  out  16; sr1, sr2  out  3 (combinational from IR).
REQ-014 busy  out  1  high while a multi-cycle op is in progress.

Function
REQ-015 Operand 1 = byp_val of lowest-index set byp_sel1 bit, else VSR1; operand 2 likewise from byp_sel2, else VSR2; op2_sel=0 replaces operand 2 with imm5 for the ALU only.
REQ-016 imm5, off6, off9, off11 sign-extended from IR to DATA_W; pcout = pcsel1 term + pcsel2 term, modulo 2^DATA_W.
REQ-017 in_ready = (state==IDLE) && (!out_valid || out_ready), combinational.
REQ-018 FSM states IDLE, MUL, HOLD; IDLE→MUL on accepting alu_op=4; MUL→HOLD after DATA_W iterations; HOLD→IDLE when result enters output register.
REQ-019 Single-cycle ops: outputs registered and out_valid high on the edge that accepts the instruction (latency 1).
REQ-020 MUL: shift-add, one multiplier bit per cycle, low DATA_W bits of product; out_valid rises exactly DATA_W+1 cycles after accept.
REQ-021 Output register holds all outputs stable while out_valid && !out_ready; out_valid clears on out_ready with no new result.
REQ-022 Simultaneous out_ready and accept: new result replaces old in the same edge, out_valid stays high.
REQ-023 dr = IR[11:9] for opcodes 0001,0101,1001,0010,0110,1010,1110, else 0; NZP = IR[11:9] for opcode 0000, else 0.
REQ-024 M_Data = resolved operand 2 (pre-imm mux) for opcodes 0011,0111,1011, else 0.
REQ-025 sr1 = IR[8:6]; sr2 = IR[2:0] for 0001/0101/1001, IR[11:9] for 0011/0111/1011, else 0.
REQ-026 Reserved alu_op yields aluout=0, other outputs normal.

Reset
REQ-027 rst forces state IDLE, out_valid 0, busy 0, all registered outputs 0, including mid-MUL (partial product discarded).
REQ-028 in_ready is 0 during the rst cycle.

Configuration
REQ-029 Macro EXEC_MC_MUL_EN: defined → MUL state and shift-add datapath compiled in per REQ-020.
REQ-030 Not defined → MUL state absent, alu_op=4 treated as reserved (REQ-026, latency 1), busy tied 0.

Structure
REQ-031 Package execute_mc_pkg holds alu_op enum, FSM state enum, opcode constants, sign-extend function.
REQ-032 One sub-module execute_mc_mul (iterative multiplier, start/done handshake), instantiated only under EXEC_MC_MUL_EN.

Verification
REQ-033 ADD, VSR1=0x0005, imm5=-3 (IR[4:0]=0x1D), op2_sel=0 → next cycle aluout=0x0002, out_valid=1.
REQ-034 byp_sel1=2'b11, byp_val={0x2222,0x1111} → operand 1 = 0x1111 (source 0 wins).
REQ-035 MUL 0x0007×0x0006, DATA_W=16 → in_ready low 17 cycles, aluout=0x002A, out_valid 17 cycles after accept.
REQ-036 out_ready held 0 for 5 cycles after result → outputs unchanged, in_ready=0; out_ready=1 → drains next edge.
REQ-037 rst asserted 4 cycles into MUL → next edge all outputs 0, state IDLE, in_ready=1 the cycle after rst drops.
REQ-038 BR with IR=0x0E05, pcsel1=1, pcsel2=1, npc_in=0x3001 → NZP=3'b111, pcout=0x3006.

Source files
------------

// File: rtl/execute_mc_pkg.sv
// rtl/execute_mc_pkg.sv - shared types, opcode constants and sign-extension helper for execute_mc
package execute_mc_pkg;

   // Width of the sign-extension scratch value; DATA_W must not exceed it.
   localparam int SEXT_W = 64;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'd0,
      ALU_AND   = 3'd1,
      ALU_NOT   = 3'd2,
      ALU_PASS2 = 3'd3,
      ALU_MUL   = 3'd4
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_LEA = 4'b1110;

   // Sign-extend the low 'bits' bits of v: park the field at the MSB, then shift back arithmetically.
   function automatic logic [SEXT_W-1:0] sext(input logic [15:0] v, input int unsigned bits);
      logic signed [SEXT_W-1:0] t;
      t = signed'({v, {(SEXT_W-16){1'b0}}});
      t = t <<< (16 - bits);
      return t >>> (SEXT_W - bits);
   endfunction

endpackage

// File: rtl/execute_mc_mul.sv
// rtl/execute_mc_mul.sv - iterative shift-add multiplier, one multiplier bit per cycle, low DATA_W bits
module execute_mc_mul
   import execute_mc_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [DATA_W-1:0] acc;
   logic [CNT_W-1:0]  cnt;
   logic              running;

   // The first partial product is taken on the start edge, so DATA_W iterations end DATA_W-1 edges later.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         cnt     <= '0;
         running <= 1'b0;
      end else if (start) begin
         acc     <= b[0] ? a : '0;
         mcand   <= a << 1;
         mplier  <= b >> 1;
         cnt     <= CNT_W'(DATA_W - 1);
         running <= 1'b1;
      end else if (running && cnt != '0) begin
         acc    <= acc + (mplier[0] ? mcand : '0);
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - 1'b1;
      end
   end

   assign done    = running && (cnt == '0);
   assign product = acc;

endmodule

// File: rtl/execute_mc.sv
// rtl/execute_mc.sv - execute stage with bypass, PC adder and registered output; EXEC_MC_MUL_EN adds multi-cycle MUL
module execute_mc
   import execute_mc_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int N_BYP  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [15:0]             IR,
   input  logic [DATA_W-1:0]       npc_in,
   input  logic [2:0]              alu_op,
   input  logic                    op2_sel,
   input  logic [1:0]              pcsel1,
   input  logic                    pcsel2,
   input  logic [DATA_W-1:0]       VSR1,
   input  logic [DATA_W-1:0]       VSR2,
   input  logic [N_BYP-1:0]        byp_sel1,
   input  logic [N_BYP-1:0]        byp_sel2,
   input  logic [N_BYP*DATA_W-1:0] byp_val,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       aluout,
   output logic [DATA_W-1:0]       pcout,
   output logic [DATA_W-1:0]       M_Data,
   output logic [2:0]              dr,
   output logic [2:0]              NZP,
   output logic [15:0]             IR_Exec,
   output logic [2:0]              sr1,
   output logic [2:0]              sr2,
   output logic                    busy
);

   state_e            state;
   logic [3:0]        opcode;
   logic [DATA_W-1:0] op1, op2, op2_alu, imm5, off6, off9, off11, pc_off, pc_base;
   logic [DATA_W-1:0] nxt_alu, nxt_pc, nxt_md;
   logic [2:0]        nxt_dr, nxt_nzp;
   logic              is_wr, is_st, out_free, accept, is_mul;

   assign opcode = IR[15:12];
   assign imm5   = DATA_W'(sext(IR, 5));
   assign off6   = DATA_W'(sext(IR, 6));
   assign off9   = DATA_W'(sext(IR, 9));
   assign off11  = DATA_W'(sext(IR, 11));

   // Walk sources from highest index down so the lowest-index requester wins.
   always_comb begin
      op1 = VSR1;
      op2 = VSR2;
      for (int k = N_BYP - 1; k >= 0; k--) begin
         if (byp_sel1[k]) op1 = byp_val[k*DATA_W +: DATA_W];
         if (byp_sel2[k]) op2 = byp_val[k*DATA_W +: DATA_W];
      end
   end

   assign op2_alu = op2_sel ? op2 : imm5;

   always_comb begin
      case (pcsel1)
         2'd0:    pc_off = off11;
         2'd1:    pc_off = off9;
         2'd2:    pc_off = off6;
         default: pc_off = '0;
      endcase
   end

   assign pc_base = pcsel2 ? npc_in : op1;
   assign nxt_pc  = pc_off + pc_base;

   always_comb begin
      case (alu_op)
         ALU_ADD:   nxt_alu = op1 + op2_alu;
         ALU_AND:   nxt_alu = op1 & op2_alu;
         ALU_NOT:   nxt_alu = ~op1;
         ALU_PASS2: nxt_alu = op2_alu;
         default:   nxt_alu = '0;
      endcase
   end

   assign is_wr   = opcode inside {OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI, OP_LEA};
   assign is_st   = opcode inside {OP_ST, OP_STR, OP_STI};
   assign nxt_dr  = is_wr ? IR[11:9] : 3'b000;
   assign nxt_nzp = (opcode == OP_BR) ? IR[11:9] : 3'b000;
   assign nxt_md  = is_st ? op2 : '0;

   assign sr1 = IR[8:6];
   always_comb begin
      if (opcode inside {OP_ADD, OP_AND, OP_NOT})
         sr2 = IR[2:0];
      else if (is_st)
         sr2 = IR[11:9];
      else
         sr2 = 3'b000;
   end

   assign out_free = !out_valid || out_ready;
   assign in_ready = !rst && (state == ST_IDLE) && out_free;
   assign accept   = in_valid && in_ready;

`ifdef EXEC_MC_MUL_EN
   logic              mul_done;
   logic [DATA_W-1:0] mul_product;
   logic [DATA_W-1:0] pend_pc, pend_md;
   logic [2:0]        pend_dr, pend_nzp;
   logic [15:0]       pend_ir;

   assign is_mul = (alu_op == ALU_MUL);
   assign busy   = (state != ST_IDLE);

   execute_mc_mul #(.DATA_W(DATA_W)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && is_mul),
      .a       (op1),
      .b       (op2_alu),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   assign is_mul = 1'b0;
   assign busy   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         aluout    <= '0;
         pcout     <= '0;
         M_Data    <= '0;
         dr        <= 3'b000;
         NZP       <= 3'b000;
         IR_Exec   <= 16'h0000;
`ifdef EXEC_MC_MUL_EN
         pend_pc   <= '0;
         pend_md   <= '0;
         pend_dr   <= 3'b000;
         pend_nzp  <= 3'b000;
         pend_ir   <= 16'h0000;
`endif
      end else begin
         if (accept && !is_mul) begin
            aluout    <= nxt_alu;
            pcout     <= nxt_pc;
            M_Data    <= nxt_md;
            dr        <= nxt_dr;
            NZP       <= nxt_nzp;
            IR_Exec   <= IR;
            out_valid <= 1'b1;
`ifdef EXEC_MC_MUL_EN
         end else if (state == ST_HOLD && out_free) begin
            aluout    <= mul_product;
            pcout     <= pend_pc;
            M_Data    <= pend_md;
            dr        <= pend_dr;
            NZP       <= pend_nzp;
            IR_Exec   <= pend_ir;
            out_valid <= 1'b1;
`endif
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
`ifdef EXEC_MC_MUL_EN
         // Side outputs of a MUL are captured at accept and released together with the product.
         case (state)
            ST_IDLE: if (accept && is_mul) begin
               state    <= ST_MUL;
               pend_pc  <= nxt_pc;
               pend_md  <= nxt_md;
               pend_dr  <= nxt_dr;
               pend_nzp <= nxt_nzp;
               pend_ir  <= IR;
            end
            ST_MUL:  if (mul_done) state <= ST_HOLD;
            ST_HOLD: if (out_free) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
`endif
      end
   end

endmodule

// File: tb/tb_execute_mc.sv
// tb/tb_execute_mc.sv - scoreboard bench for execute_mc with directed vectors
module tb_execute_mc;

   localparam int DW = 16;
   localparam int NB = 2;
`ifdef EXEC_MC_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready, out_valid, out_ready;
   logic [15:0]     IR, IR_Exec;
   logic [DW-1:0]   npc_in, VSR1, VSR2, aluout, pcout, M_Data;
   logic [2:0]      alu_op, dr, NZP, sr1, sr2;
   logic            op2_sel, pcsel2, busy;
   logic [1:0]      pcsel1;
   logic [NB-1:0]   byp_sel1, byp_sel2;
   logic [NB*DW-1:0] byp_val;

   typedef struct packed {
      logic [15:0] alu;
      logic [15:0] pc;
      logic [15:0] md;
      logic [2:0]  dr;
      logic [2:0]  nzp;
      logic [15:0] ir;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   execute_mc #(.DATA_W(DW), .N_BYP(NB)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .IR(IR), .npc_in(npc_in), .alu_op(alu_op), .op2_sel(op2_sel),
      .pcsel1(pcsel1), .pcsel2(pcsel2), .VSR1(VSR1), .VSR2(VSR2),
      .byp_sel1(byp_sel1), .byp_sel2(byp_sel2), .byp_val(byp_val),
      .out_valid(out_valid), .out_ready(out_ready), .aluout(aluout),
      .pcout(pcout), .M_Data(M_Data), .dr(dr), .NZP(NZP), .IR_Exec(IR_Exec),
      .sr1(sr1), .sr2(sr2), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] a, input logic [15:0] p, input logic [15:0] m,
                               input logic [2:0] d, input logic [2:0] n, input logic [15:0] i);
      return {a, p, m, d, n, i};
   endfunction

   // Monitor: each result is checked on the cycle it is consumed downstream.
   always @(negedge clk) begin : monitor
      exp_t got, e;
      if (!rst && out_valid && out_ready) begin
         got = {aluout, pcout, M_Data, dr, NZP, IR_Exec};
         tests++;
         if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got %h expected no output", got);
         end else begin
            e = sb_q.pop_front();
            if (got !== e) begin
               fails++;
               $display("FAIL sb_result: got %h expected %h", got, e);
            end
         end
      end
   end

   task automatic send(input logic [15:0] ir, input logic [2:0] op, input logic o2s,
                       input logic [1:0] ps1, input logic ps2, input logic [15:0] v1,
                       input logic [15:0] v2, input logic [1:0] b1, input logic [1:0] b2,
                       input logic [31:0] bv, input logic [15:0] npc, input exp_t e, input bit push);
      int n;
      @(negedge clk);
      IR = ir; alu_op = op; op2_sel = o2s; pcsel1 = ps1; pcsel2 = ps2;
      VSR1 = v1; VSR2 = v2; byp_sel1 = b1; byp_sel2 = b2; byp_val = bv; npc_in = npc;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: in_ready got 0 expected 1 within 200 cycles");
         in_valid = 1'b0;
      end else begin
         if (push) sb_q.push_back(e);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_timeout", 32'(sb_q.size()), 32'd0);
   endtask

   logic [15:0] sr_ir [4]  = '{16'h147D, 16'h76BE, 16'h0E05, 16'hB5C0};
   logic [2:0]  sr1_x [4]  = '{3'd1, 3'd2, 3'd0, 3'd7};
   logic [2:0]  sr2_x [4]  = '{3'd5, 3'd3, 3'd0, 3'd2};

   initial begin
      int first, low;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      IR = 16'h0000; alu_op = 3'd0; op2_sel = 1'b0; pcsel1 = 2'd0; pcsel2 = 1'b0;
      VSR1 = '0; VSR2 = '0; byp_sel1 = '0; byp_sel2 = '0; byp_val = '0; npc_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_outputs", 32'({aluout, pcout} | 32'({M_Data, dr, NZP})), 32'd0);
      chk("rst_ir_exec", 32'(IR_Exec), 32'd0);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 4; i++) begin
         IR = sr_ir[i];
         #1;
         chk("sr1", 32'(sr1), 32'(sr1_x[i]));
         chk("sr2", 32'(sr2), 32'(sr2_x[i]));
      end

      send(16'h147D, 3'd0, 1'b0, 2'd3, 1'b1, 16'h0005, 16'h9999, 2'b00, 2'b00, 32'h0, 16'h3000,
           mk(16'h0002, 16'h3000, 16'h0000, 3'd2, 3'd0, 16'h147D), 1'b1);
      chk("add_latency_valid", 32'(out_valid), 32'd1);
      chk("add_imm_aluout", 32'(aluout), 32'h0002);
      send(16'h1642, 3'd0, 1'b1, 2'd3, 1'b1, 16'h0AAA, 16'h0003, 2'b11, 2'b00, 32'h2222_1111, 16'h0000,
           mk(16'h1114, 16'h0000, 16'h0000, 3'd3, 3'd0, 16'h1642), 1'b1);
      send(16'h5801, 3'd1, 1'b1, 2'd3, 1'b1, 16'hFF0F, 16'h0000, 2'b00, 2'b10, 32'h2222_1111, 16'h0000,
           mk(16'h2202, 16'h0000, 16'h0000, 3'd4, 3'd0, 16'h5801), 1'b1);
      send(16'h9BBF, 3'd2, 1'b1, 2'd3, 1'b1, 16'h00F0, 16'h0000, 2'b00, 2'b00, 32'h0, 16'h0000,
           mk(16'hFF0F, 16'h0000, 16'h0000, 3'd5, 3'd0, 16'h9BBF), 1'b1);
      send(16'hEC04, 3'd3, 1'b0, 2'd1, 1'b1, 16'h1111, 16'h2222, 2'b00, 2'b00, 32'h0, 16'h4000,
           mk(16'h0004, 16'h4004, 16'h0000, 3'd6, 3'd0, 16'hEC04), 1'b1);
      send(16'h76BE, 3'd0, 1'b0, 2'd2, 1'b0, 16'h5000, 16'hBEEF, 2'b00, 2'b00, 32'h0, 16'h0000,
           mk(16'h4FFE, 16'h4FFE, 16'hBEEF, 3'd0, 3'd0, 16'h76BE), 1'b1);
      send(16'h0E05, 3'd3, 1'b1, 2'd1, 1'b1, 16'h0000, 16'h1234, 2'b00, 2'b00, 32'h0, 16'h3001,
           mk(16'h1234, 16'h3006, 16'h0000, 3'd0, 3'b111, 16'h0E05), 1'b1);
      send(16'h147D, 3'd5, 1'b0, 2'd0, 1'b1, 16'h0005, 16'h0000, 2'b00, 2'b00, 32'h0, 16'h0100,
           mk(16'h0000, 16'hFD7D, 16'h0000, 3'd2, 3'd0, 16'h147D), 1'b1);
      send(16'hB5C0, 3'd7, 1'b0, 2'd3, 1'b0, 16'h0042, 16'h7777, 2'b00, 2'b01, 32'h2222_1111, 16'h0000,
           mk(16'h0000, 16'h0042, 16'h1111, 3'd0, 3'd0, 16'hB5C0), 1'b1);
      send(16'h1642, 3'd0, 1'b1, 2'd2, 1'b1, 16'hFFFF, 16'h0002, 2'b00, 2'b00, 32'h0, 16'hFFFF,
           mk(16'h0001, 16'h0001, 16'h0000, 3'd3, 3'd0, 16'h1642), 1'b1);
      wait_drain();

      // Backpressure: result must hold and block new input until drained.
      repeat (2) @(posedge clk);
      #1 out_ready = 1'b0;
      send(16'h147D, 3'd0, 1'b0, 2'd3, 1'b1, 16'h0010, 16'h0000, 2'b00, 2'b00, 32'h0, 16'h2000,
           mk(16'h000D, 16'h2000, 16'h0000, 3'd2, 3'd0, 16'h147D), 1'b1);
      VSR1 = 16'hAAAA; IR = 16'h9BBF;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_aluout", 32'(aluout), 32'h000D);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_drained", 32'(out_valid), 32'd0);

      send(16'h147D, 3'd0, 1'b0, 2'd3, 1'b1, 16'h0001, 16'h0000, 2'b00, 2'b00, 32'h0, 16'h0000,
           mk(16'hFFFE, 16'h0000, 16'h0000, 3'd2, 3'd0, 16'h147D), 1'b1);
      send(16'h147D, 3'd0, 1'b0, 2'd3, 1'b1, 16'h0100, 16'h0000, 2'b00, 2'b00, 32'h0, 16'h0000,
           mk(16'h00FD, 16'h0000, 16'h0000, 3'd2, 3'd0, 16'h147D), 1'b1);
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_aluout", 32'(aluout), 32'h00FD);
      wait_drain();

      send(16'h1642, 3'd4, 1'b1, 2'd3, 1'b1, 16'h0007, 16'h0006, 2'b00, 2'b00, 32'h0, 16'h1000,
           mk(MUL_ON ? 16'h002A : 16'h0000, 16'h1000, 16'h0000, 3'd3, 3'd0, 16'h1642), 1'b1);
      first = 0;
      low = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (i == 1) chk("mul_busy", 32'(busy), 32'(MUL_ON));
         if (out_valid && first == 0) first = i;
         if (!in_ready) low++;
         if (first != 0 && in_ready) break;
      end
      chk("mul_out_valid_edge", 32'(first), MUL_ON ? 32'd18 : 32'd1);
      chk("mul_in_ready_low", 32'(low), MUL_ON ? 32'd17 : 32'd0);
      wait_drain();
      chk("mul_busy_after", 32'(busy), 32'd0);

      send(16'h1642, 3'd4, 1'b1, 2'd3, 1'b1, 16'hFFFF, 16'hFFFF, 2'b00, 2'b00, 32'h0, 16'h0000,
           mk(MUL_ON ? 16'h0001 : 16'h0000, 16'h0000, 16'h0000, 3'd3, 3'd0, 16'h1642), 1'b1);
      wait_drain();

      // Reset four cycles into a MUL: partial result discarded, everything zeroed.
      send(16'h1642, 3'd4, 1'b1, 2'd1, 1'b1, 16'h0007, 16'h0006, 2'b00, 2'b00, 32'h0, 16'h3000,
           mk(16'h0000, 16'h3042, 16'h0000, 3'd3, 3'd0, 16'h1642), !MUL_ON);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("midmul_rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("midmul_out_valid", 32'(out_valid), 32'd0);
      chk("midmul_busy", 32'(busy), 32'd0);
      chk("midmul_alu_pc", 32'({aluout, pcout}), 32'd0);
      chk("midmul_md_dr_nzp", 32'({M_Data, dr, NZP}), 32'd0);
      chk("midmul_ir_exec", 32'(IR_Exec), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("midmul_in_ready_after", 32'(in_ready), 32'd1);
      repeat (30) @(posedge clk);
      #1 chk("midmul_no_result", 32'(out_valid), 32'd0);

      send(16'h147D, 3'd0, 1'b0, 2'd3, 1'b1, 16'h0003, 16'h0000, 2'b00, 2'b00, 32'h0, 16'h0000,
           mk(16'h0000, 16'h0000, 16'h0000, 3'd2, 3'd0, 16'h147D), 1'b1);
      wait_drain();
      repeat (3) @(posedge clk);
      #1 chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
